// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl: clock-enable scheduler for the multicycle CPU.
//
// Everything runs on I_CLK. The CPU advances only in cycles where cpu_ce=1.
// The source of those pulses is selected by mode: halt, full speed, every
// DIV-th cycle, or one pulse per debounced push of step_btn. A halt latch
// set by the CPU overrides the selected mode until resume.
//
// Ports:
//   I_CLK     in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   mode      in   [1:0] 00 halt, 01 run, 10 divided, 11 single-step (async)
//   step_btn  in   raw step push-button (async)
//   cpu_halt  in   CPU halt level; its rising edge sets the halt latch
//   resume    in   one-cycle pulse clearing the halt latch
//   cpu_ce    out  CPU clock enable, one cycle per CPU cycle
//   O_CLK     out  heartbeat, toggles with every cpu_ce pulse
//   halted    out  halt latch
//   state     out  [1:0] effective mode (00 whenever halted)
//   cycle_cnt out  [CNT_W-1:0] number of cpu_ce pulses since reset
module clk_step_ctrl #(
    parameter int unsigned DIV   = 50000000,
    parameter int unsigned DEB   = 1000000,
    parameter int unsigned CNT_W = 32
) (
    input  logic             I_CLK,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             step_btn,
    input  logic             cpu_halt,
    input  logic             resume,
    output logic             cpu_ce,
    output logic             O_CLK,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [1:0] ST_HALT = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DIV  = 2'b10;
    localparam logic [1:0] ST_STEP = 2'b11;

    localparam int unsigned DIV_W = $clog2(DIV);
    localparam int unsigned DEB_W = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB - 1);

    logic [1:0]       mode_s1_q, mode_s2_q;
    logic             btn_s1_q, btn_s2_q;
    logic             halt_prev_q;
    logic             halted_q, halted_d;
    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             deb_lvl_q, deb_lvl_d;
    logic             ce_q, ce_d;
    logic             oclk_q, oclk_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;

    logic halt_rise;
    logic steady;
    logic div_hit;
    logic step_rise;

    always_comb begin
        halt_rise = cpu_halt & ~halt_prev_q;
        // A new halt edge beats a simultaneous resume.
        halted_d  = halt_rise | (halted_q & ~resume);

        // state_d is next cycle's effective mode; state_q is this cycle's.
        state_d = (halted_d || (mode_s2_q == ST_HALT)) ? ST_HALT : mode_s2_q;
        steady  = (state_d == state_q);

        // Debounce: count consecutive cycles that disagree with the
        // accepted level; any agreeing cycle restarts the count.
        deb_lvl_d = deb_lvl_q;
        deb_cnt_d = '0;
        if (btn_s2_q != deb_lvl_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_lvl_d = btn_s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
        // The debouncer runs in every mode, so a button already held when
        // STEP is entered has no rising edge left to report.
        step_rise = deb_lvl_d & ~deb_lvl_q;

        // The divider restarts at 0 on every mode change and stays at 0
        // outside DIV; the pulse lands DIV cycles after entry.
        div_hit   = (div_cnt_q == DIV_LAST);
        div_cnt_d = '0;
        if (steady && (state_d == ST_DIV) && !div_hit) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        case (state_d)
            ST_RUN:  ce_d = 1'b1;
            ST_DIV:  ce_d = div_hit;
            ST_STEP: ce_d = step_rise;
            default: ce_d = 1'b0;
        endcase
        // No pulse in the cycle the effective mode changes.
        ce_d = ce_d & steady;

        oclk_d = oclk_q ^ ce_d;
        cyc_d  = cyc_q + CNT_W'(ce_d);
    end

    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            mode_s1_q   <= '0;
            mode_s2_q   <= '0;
            btn_s1_q    <= 1'b0;
            btn_s2_q    <= 1'b0;
            halt_prev_q <= 1'b0;
            halted_q    <= 1'b0;
            state_q     <= ST_HALT;
            div_cnt_q   <= '0;
            deb_cnt_q   <= '0;
            deb_lvl_q   <= 1'b0;
            ce_q        <= 1'b0;
            oclk_q      <= 1'b0;
            cyc_q       <= '0;
        end else begin
            mode_s1_q   <= mode;
            mode_s2_q   <= mode_s1_q;
            btn_s1_q    <= step_btn;
            btn_s2_q    <= btn_s1_q;
            halt_prev_q <= cpu_halt;
            halted_q    <= halted_d;
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            deb_lvl_q   <= deb_lvl_d;
            ce_q        <= ce_d;
            oclk_q      <= oclk_d;
            cyc_q       <= cyc_d;
        end
    end

    assign cpu_ce    = ce_q;
    assign O_CLK     = oclk_q;
    assign halted    = halted_q;
    assign state     = state_q;
    assign cycle_cnt = cyc_q;

endmodule

// File: doc/clk_step_ctrl.md
Name: clk_step_ctrl

Overview:
- Clock-enable scheduler for the multicycle CPU.
- Turns the board clock into single-cycle CPU clock-enable pulses using one of four modes: halt, full speed, divided rate, or debounced single-step.
- Honours a halt request from the CPU and counts every CPU cycle it issues.
- Replaces derived clocks: the CPU and the divider heartbeat both run on I_CLK and are gated by cpu_ce.

Parameters:
- DIV, 50000000: I_CLK cycles between cpu_ce pulses in divided mode (≥2).
- DEB, 1000000: consecutive stable I_CLK cycles required to accept a step-button level change (≥1).
- CNT_W, 32: width of the issued-cycle counter.

Ports:
- I_CLK, input, 1: system clock; all logic is on the rising edge.
- rst, input, 1: asynchronous, active-high reset. This is the only reset.
- mode, input, 2: 00 halt, 01 full speed, 10 divided, 11 single-step. Quasi-static switch input, synchronised internally.
- step_btn, input, 1: raw push-button, asynchronous to I_CLK.
- cpu_halt, input, 1: level from the CPU; high means the CPU has executed a halt.
- resume, input, 1: one-cycle pulse that clears the halted condition.
- cpu_ce, output, 1: CPU clock enable; one I_CLK cycle wide per CPU cycle.
- O_CLK, output, 1: heartbeat; toggles on every cpu_ce pulse (LED).
- halted, output, 1: halt latch.
- state, output, 2: effective mode (00 whenever halted).
- cycle_cnt, output, CNT_W: number of cpu_ce pulses issued since reset.

Behaviour:
- Reset: all outputs are 0. Counters, synchronisers, the debounce state (stable level = 0) and the halt latch are cleared. Reset takes effect immediately regardless of I_CLK.
- Input synchronisation: mode and step_btn each pass through a 2-FF synchroniser. All decisions use the synchronised values, so there are 2 cycles of input latency.
- Effective state:
  - HALT when halted=1 or sync mode=00.
  - Otherwise RUN (01), DIV (10) or STEP (11) according to sync mode.
  - state is registered and reflects the effective state of the current cycle.
- HALT: cpu_ce=0. The divider count is held at 0.
- RUN: cpu_ce=1 every cycle.
- DIV:
  - Count runs 0..DIV-1.
  - cpu_ce=1 in the cycle the count equals DIV-1; the count then wraps to 0.
  - The first pulse after entering DIV arrives DIV cycles after entry.
- STEP:
  - The debouncer tracks the synchronised button. The accepted level changes only after DEB consecutive cycles of the new value; any bounce restarts the count.
  - A 0→1 transition of the accepted level produces exactly one cpu_ce pulse, in the cycle after acceptance.
  - Release produces no pulse.
  - A button held across entry into STEP does not pulse.
- Mode change: any change of effective state clears the divider count. No cpu_ce is issued in the transition cycle.
- Halt latch:
  - halted sets on a rising edge of cpu_halt (registered edge detect).
  - It blocks cpu_ce starting the cycle after the edge.
  - resume=1 clears it. If a cpu_halt rising edge and resume occur in the same cycle, set wins.
  - A cpu_halt level that stays high after resume does not re-halt.
- cycle_cnt: increments by 1 with every cpu_ce pulse and wraps modulo 2^CNT_W.
- O_CLK: toggles in the same cycle that cpu_ce=1 is registered.
- Outputs are registered: cpu_ce is a flop output with no combinational path from inputs.
- Reset mid-operation: any in-progress divide count, debounce count or pending step pulse is discarded. No pulse is issued after reset deasserts until the normal rules allow one.

Test Plan:
Directed scenarios use DIV=4, DEB=3.
1. Reset, mode=01 held → after synchroniser latency, cpu_ce=1 every cycle; cycle_cnt reaches 10 after 10 pulses; O_CLK ends at 0.
2. mode=10 → cpu_ce pulses exactly every 4th cycle, first pulse 4 cycles after state=10; switch to 01 mid-count → no pulse in the transition cycle.
3. mode=11, step_btn bounces 1,0,1,0 then holds 1 for 6 cycles, then 0 for 6 → exactly one cpu_ce pulse, 1 cycle after 3 stable highs; cycle_cnt increments by 1.
4. mode=01, raise cpu_halt → halted=1 and state=00, cpu_ce=0 from the next cycle; pulse resume while cpu_halt stays high → running resumes with no re-halt; drop and re-raise cpu_halt → halts again.
5. resume and a cpu_halt rising edge in the same cycle → halted=1.
6. Assert rst asynchronously mid-DIV count and mid-debounce → all outputs 0 immediately; after release in DIV mode, the first pulse arrives a full 4 cycles after state=10.
